pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter register and fetch sequencer for the 8-bit core.
- Sits directly downstream of the 4-to-1 next-PC select mux. It drives that mux's select code and its PC+1 input, and registers the mux output as the new PC.
- Provides the start/done run handshake to the test harness.
- Provides the fetch-valid qualifier to instruction memory and decode.

Parameters:
PC_WIDTH, 10, width of the program counter (1024-entry instruction memory).
RESET_VECTOR, 0, PC value loaded at reset; also the value the harness places on mux input 3.
CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  pulse: begin a program run from RESET_VECTOR.
stall  input  1  hold the current instruction this cycle (no retire, no PC update).
halt  input  1  the current instruction is a halt.
branch_taken  input  1  the current instruction is a taken conditional branch.
jump  input  1  the current instruction is an unconditional jump.
next_pc  input  PC_WIDTH  output of the next-PC mux.
pc_sel  output  2  mux select: 00 = PC+1, 01 = branch target, 10 = jump target, 11 = reset vector.
pc_plus1  output  PC_WIDTH  pc + 1, fed to mux input 0.
pc  output  PC_WIDTH  current PC, addresses instruction memory.
fetch_valid  output  1  pc holds a live instruction address.
busy  output  1  run in progress.
done  output  1  program halted; level output.
instr_count  output  CNT_WIDTH  instructions retired in the current or last run.

Behaviour:
- States: IDLE, RUN, DONE. State is held in registers; all outputs except pc_sel and pc_plus1 are registered or decoded from registered state.
- Reset (rst_n low, any time, asynchronous):
  - state = IDLE, pc = RESET_VECTOR, instr_count = 0, done = 0, busy = 0, fetch_valid = 0.
  - Reset asserted mid-run aborts the run; no partial state survives.
- Combinational outputs:
  - pc_plus1 = pc + 1 modulo 2^PC_WIDTH, so the maximum PC wraps to 0.
  - pc_sel in IDLE or DONE = 11.
  - pc_sel in RUN = 10 if jump; else 01 if branch_taken; else 00. jump beats branch_taken.
  - pc_sel does not depend on stall or halt.
- Decoded outputs:
  - fetch_valid = (state == RUN).
  - busy = (state == RUN).
  - done = (state == DONE).
- IDLE or DONE with start = 1:
  - pc <= next_pc (equals RESET_VECTOR because pc_sel = 11).
  - instr_count <= 0.
  - state <= RUN.
  - done deasserts in the same edge.
  - First fetch_valid cycle is the cycle after start.
- IDLE or DONE with start = 0: everything holds.
- RUN with stall = 1: pc, instr_count and state hold. stall masks halt, jump and branch_taken.
- RUN with stall = 0 and halt = 0:
  - pc <= next_pc.
  - instr_count increments by 1, saturating at all-ones.
- RUN with stall = 0 and halt = 1:
  - pc holds at the halt address.
  - instr_count increments by 1, so the halt counts as retired.
  - state <= DONE, so done is high starting the next cycle.
  - halt takes priority over jump and branch_taken asserted in the same cycle.
- start while in RUN is ignored.
- Latency:
  - A redirect (branch or jump) takes effect at the next edge.
  - No delay slots and no bubbles are generated by this block.
- instr_count and pc hold their values in DONE until the next start.

Test Plan:
- Reset/idle: assert rst_n = 0 mid-cycle -> pc = 0, done = 0, busy = 0, pc_sel = 11 immediately; hold start = 0 for 5 cycles -> all outputs unchanged.
- Sequential run: pulse start, mux models PC+1, halt at pc = 5 -> pc sequence 0,1,2,3,4,5; done = 1 one cycle after the halt cycle; instr_count = 6; pc stays 5.
- Redirect priority:
  - At pc = 2, jump = 1 and branch_taken = 1 -> pc_sel = 10, pc = jump target 40 next cycle.
  - At pc = 41, branch_taken only -> pc_sel = 01.
  - At pc = 43, halt = 1 with jump = 1 -> halt wins; pc stays 43.
- Stall: stall = 1 for 3 cycles at pc = 3 with halt = 1 and jump = 1 asserted -> pc stays 3, instr_count frozen, no DONE; release stall with halt = 0 -> pc = 4 next cycle.
- Boundaries:
  - PC_WIDTH = 4 with pc = 15 sequential -> pc_plus1 = 0, pc wraps to 0.
  - CNT_WIDTH = 3 with 10 retires -> instr_count saturates at 7.
  - start during RUN -> ignored.
  - start in DONE -> pc = 0, count = 0, new run begins.
- Reset mid-run: drop rst_n at pc = 7 -> immediate IDLE, pc = 0; a new start runs normally from 0.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and IDLE/RUN/DONE fetch sequencer for the 8-bit core.
// Drives the next-PC mux select and PC+1 input, and registers the mux output as the new PC.
module pc_fetch_ctrl #(
  parameter int unsigned         PC_WIDTH     = 10,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned         CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 branch_taken,
  input  logic                 jump,
  input  logic [PC_WIDTH-1:0]  next_pc,
  output logic [1:0]           pc_sel,
  output logic [PC_WIDTH-1:0]  pc_plus1,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 fetch_valid,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] SEL_INC = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_JMP = 2'b10;
  localparam logic [1:0] SEL_RST = 2'b11;

  logic [1:0] state;

  assign pc_plus1    = pc + PC_WIDTH'(1);
  assign fetch_valid = (state == RUN);
  assign busy        = (state == RUN);
  assign done        = (state == DONE);

  // Select ignores stall and halt; those only gate the register update.
  always_comb begin
    pc_sel = SEL_RST;
    if (state == RUN) begin
      if (jump)              pc_sel = SEL_JMP;
      else if (branch_taken) pc_sel = SEL_BR;
      else                   pc_sel = SEL_INC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pc          <= next_pc;
            instr_count <= '0;
            state       <= RUN;
          end
        end
        RUN: begin
          if (!stall) begin
            if (instr_count != '1) instr_count <= instr_count + CNT_WIDTH'(1);
            if (halt) state <= DONE;
            else      pc    <= next_pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: a default-width instance and a narrow
// (4-bit PC, 3-bit count) instance driven together, checked against a behavioural model.
module tb_pc_fetch_ctrl;

  logic       clk, rst_n;
  logic       start, stall, halt, branch_taken, jump;
  logic [9:0] jt, bt;

  logic [1:0]  m_sel, s_sel;
  logic [9:0]  m_plus1, m_pc_o, m_next;
  logic [3:0]  s_plus1, s_pc_o, s_next;
  logic        m_fv, m_busy, m_done, s_fv, s_busy, s_done;
  logic [15:0] m_cnt_o;
  logic [2:0]  s_cnt_o;

  int checks = 0;
  int errors = 0;

  int m_pc, m_cnt, s_pc, s_cnt;
  bit m_run, m_fin;

  pc_fetch_ctrl #(.PC_WIDTH(10), .RESET_VECTOR(10'd0), .CNT_WIDTH(16)) dut_main (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
    .branch_taken(branch_taken), .jump(jump), .next_pc(m_next),
    .pc_sel(m_sel), .pc_plus1(m_plus1), .pc(m_pc_o), .fetch_valid(m_fv),
    .busy(m_busy), .done(m_done), .instr_count(m_cnt_o)
  );

  pc_fetch_ctrl #(.PC_WIDTH(4), .RESET_VECTOR(4'd0), .CNT_WIDTH(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
    .branch_taken(branch_taken), .jump(jump), .next_pc(s_next),
    .pc_sel(s_sel), .pc_plus1(s_plus1), .pc(s_pc_o), .fetch_valid(s_fv),
    .busy(s_busy), .done(s_done), .instr_count(s_cnt_o)
  );

  // Harness-side next-PC muxes (mux input 3 carries the reset vector 0).
  always_comb begin
    case (m_sel)
      2'b00:   m_next = m_plus1;
      2'b01:   m_next = bt;
      2'b10:   m_next = jt;
      default: m_next = 10'd0;
    endcase
    case (s_sel)
      2'b00:   s_next = s_plus1;
      2'b01:   s_next = bt[3:0];
      2'b10:   s_next = jt[3:0];
      default: s_next = 4'd0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_pc = 0; s_pc = 0; m_cnt = 0; s_cnt = 0; m_run = 0; m_fin = 0;
  endfunction

  function automatic void model_step();
    if (!m_run) begin
      if (start) begin
        m_pc = 0; s_pc = 0; m_cnt = 0; s_cnt = 0; m_run = 1; m_fin = 0;
      end
    end else if (!stall) begin
      m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
      s_cnt = (s_cnt == 7) ? s_cnt : s_cnt + 1;
      if (halt) begin
        m_run = 0; m_fin = 1;
      end else if (jump) begin
        m_pc = jt % 1024; s_pc = jt % 16;
      end else if (branch_taken) begin
        m_pc = bt % 1024; s_pc = bt % 16;
      end else begin
        m_pc = (m_pc + 1) % 1024; s_pc = (s_pc + 1) % 16;
      end
    end
  endfunction

  function automatic logic [1:0] model_sel();
    if (!m_run) return 2'b11;
    if (jump) return 2'b10;
    if (branch_taken) return 2'b01;
    return 2'b00;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    start = 0; stall = 0; halt = 0; branch_taken = 0; jump = 0;
  endtask

  task automatic test_reset();
    rst_n = 1; clear_ctrl(); jt = '0; bt = '0;
    #3 rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (m_pc_o !== 10'd0 || m_done !== 1'b0 || m_busy !== 1'b0 || m_sel !== 2'b11)
      begin errors++; $display("FAIL reset_async: pc=%0d done=%b busy=%b sel=%b required pc=0 done=0 busy=0 sel=11", m_pc_o, m_done, m_busy, m_sel); end
    checks++;
    if (m_cnt_o !== 16'd0 || m_fv !== 1'b0 || s_pc_o !== 4'd0 || s_cnt_o !== 3'd0)
      begin errors++; $display("FAIL reset_regs: cnt=%0d fv=%b s_pc=%0d s_cnt=%0d required all 0", m_cnt_o, m_fv, s_pc_o, s_cnt_o); end
    #3 rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (m_pc_o !== 10'd0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_sel !== 2'b11 || m_cnt_o !== 16'd0 || m_fv !== 1'b0)
        begin errors++; $display("FAIL idle_hold[%0d]: pc=%0d busy=%b done=%b sel=%b cnt=%0d fv=%b required 0/0/0/11/0/0", i, m_pc_o, m_busy, m_done, m_sel, m_cnt_o, m_fv); end
    end
  endtask

  task automatic test_sequential();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (m_pc_o !== 10'(i) || s_pc_o !== 4'(i))
        begin errors++; $display("FAIL seq_pc[%0d]: pc=%0d s_pc=%0d required %0d", i, m_pc_o, s_pc_o, i); end
      checks++;
      if (m_fv !== 1'b1 || m_busy !== 1'b1 || m_done !== 1'b0)
        begin errors++; $display("FAIL seq_flags[%0d]: fv=%b busy=%b done=%b required 1/1/0", i, m_fv, m_busy, m_done); end
      halt = (i == 5);
      #1;
      checks++;
      if (m_sel !== 2'b00 || m_plus1 !== 10'(i + 1))
        begin errors++; $display("FAIL seq_sel[%0d]: sel=%b plus1=%0d required 00/%0d", i, m_sel, m_plus1, i + 1); end
      tick();
    end
    halt = 0;
    checks++;
    if (m_done !== 1'b1 || m_busy !== 1'b0 || m_fv !== 1'b0 || m_pc_o !== 10'd5)
      begin errors++; $display("FAIL seq_done: done=%b busy=%b fv=%b pc=%0d required 1/0/0/5", m_done, m_busy, m_fv, m_pc_o); end
    checks++;
    if (m_cnt_o !== 16'd6 || s_cnt_o !== 3'd6 || m_sel !== 2'b11)
      begin errors++; $display("FAIL seq_count: cnt=%0d s_cnt=%0d sel=%b required 6/6/11", m_cnt_o, s_cnt_o, m_sel); end
    tick();
    checks++;
    if (m_pc_o !== 10'd5 || m_done !== 1'b1 || m_cnt_o !== 16'd6)
      begin errors++; $display("FAIL done_hold: pc=%0d done=%b cnt=%0d required 5/1/6", m_pc_o, m_done, m_cnt_o); end
  endtask

  task automatic test_redirect();
    start = 1; tick(); start = 0;
    tick(); tick();
    jump = 1; branch_taken = 1; jt = 10'd40; bt = 10'd20;
    #1;
    checks++;
    if (m_pc_o !== 10'd2 || m_sel !== 2'b10 || s_sel !== 2'b10)
      begin errors++; $display("FAIL redir_jsel: pc=%0d sel=%b s_sel=%b required 2/10/10", m_pc_o, m_sel, s_sel); end
    tick();
    checks++;
    if (m_pc_o !== 10'd40 || s_pc_o !== 4'd8)
      begin errors++; $display("FAIL redir_jpc: pc=%0d s_pc=%0d required 40/8", m_pc_o, s_pc_o); end
    jump = 0; branch_taken = 0;
    tick();
    branch_taken = 1; bt = 10'd43;
    #1;
    checks++;
    if (m_pc_o !== 10'd41 || m_sel !== 2'b01)
      begin errors++; $display("FAIL redir_bsel: pc=%0d sel=%b required 41/01", m_pc_o, m_sel); end
    tick();
    branch_taken = 0;
    checks++;
    if (m_pc_o !== 10'd43 || s_pc_o !== 4'd11)
      begin errors++; $display("FAIL redir_bpc: pc=%0d s_pc=%0d required 43/11", m_pc_o, s_pc_o); end
    halt = 1; jump = 1; jt = 10'd99;
    #1;
    checks++;
    if (m_sel !== 2'b10)
      begin errors++; $display("FAIL halt_sel: sel=%b required 10", m_sel); end
    tick();
    halt = 0; jump = 0;
    checks++;
    if (m_pc_o !== 10'd43 || m_done !== 1'b1 || m_cnt_o !== 16'd6)
      begin errors++; $display("FAIL halt_prio: pc=%0d done=%b cnt=%0d required 43/1/6", m_pc_o, m_done, m_cnt_o); end
  endtask

  task automatic test_stall();
    start = 1; tick(); start = 0;
    tick(); tick(); tick();
    stall = 1; halt = 1; jump = 1; jt = 10'd100;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (m_pc_o !== 10'd3 || m_cnt_o !== 16'd3 || m_busy !== 1'b1 || m_done !== 1'b0)
        begin errors++; $display("FAIL stall_hold[%0d]: pc=%0d cnt=%0d busy=%b done=%b required 3/3/1/0", i, m_pc_o, m_cnt_o, m_busy, m_done); end
    end
    stall = 0; halt = 0; jump = 0;
    tick();
    checks++;
    if (m_pc_o !== 10'd4 || m_cnt_o !== 16'd4)
      begin errors++; $display("FAIL stall_release: pc=%0d cnt=%0d required 4/4", m_pc_o, m_cnt_o); end
    halt = 1; tick(); halt = 0;
  endtask

  task automatic test_wrap_saturate();
    start = 1; tick(); start = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (s_pc_o !== 4'(k % 16) || s_cnt_o !== 3'((k > 7) ? 7 : k) || m_cnt_o !== 16'(k))
        begin errors++; $display("FAIL wrap_sat[%0d]: s_pc=%0d s_cnt=%0d cnt=%0d required %0d/%0d/%0d", k, s_pc_o, s_cnt_o, m_cnt_o, k % 16, (k > 7) ? 7 : k, k); end
      if (k == 15) begin
        checks++;
        if (s_plus1 !== 4'd0)
          begin errors++; $display("FAIL wrap_plus1: s_plus1=%0d required 0", s_plus1); end
      end
    end
    halt = 1; tick(); halt = 0;
  endtask

  task automatic test_start_in_run_and_done();
    start = 1; tick();
    tick(); tick();
    start = 0;
    checks++;
    if (m_pc_o !== 10'd2 || m_cnt_o !== 16'd2 || m_busy !== 1'b1)
      begin errors++; $display("FAIL start_in_run: pc=%0d cnt=%0d busy=%b required 2/2/1", m_pc_o, m_cnt_o, m_busy); end
    halt = 1; tick(); halt = 0;
    start = 1; tick(); start = 0;
    checks++;
    if (m_pc_o !== 10'd0 || m_cnt_o !== 16'd0 || m_busy !== 1'b1 || m_done !== 1'b0)
      begin errors++; $display("FAIL start_in_done: pc=%0d cnt=%0d busy=%b done=%b required 0/0/1/0", m_pc_o, m_cnt_o, m_busy, m_done); end
    halt = 1; tick(); halt = 0;
  endtask

  task automatic test_reset_midrun();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (m_pc_o !== 10'd7)
      begin errors++; $display("FAIL midrun_pre: pc=%0d required 7", m_pc_o); end
    #2 rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (m_pc_o !== 10'd0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_sel !== 2'b11 || m_cnt_o !== 16'd0)
      begin errors++; $display("FAIL midrun_reset: pc=%0d busy=%b done=%b sel=%b cnt=%0d required 0/0/0/11/0", m_pc_o, m_busy, m_done, m_sel, m_cnt_o); end
    #2 rst_n = 1;
    @(posedge clk); #1;
    start = 1; tick(); start = 0;
    tick(); tick(); tick();
    checks++;
    if (m_pc_o !== 10'd3 || m_cnt_o !== 16'd3 || m_busy !== 1'b1)
      begin errors++; $display("FAIL midrun_restart: pc=%0d cnt=%0d busy=%b required 3/3/1", m_pc_o, m_cnt_o, m_busy); end
    halt = 1; tick(); halt = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      start        = ($urandom_range(0, 5) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      halt         = ($urandom_range(0, 15) == 0);
      jump         = ($urandom_range(0, 7) == 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      jt           = 10'($urandom_range(0, 1023));
      bt           = 10'($urandom_range(0, 1023));
      #1;
      checks++;
      if (m_sel !== model_sel() || s_sel !== model_sel() || m_plus1 !== 10'((m_pc + 1) % 1024) || s_plus1 !== 4'((s_pc + 1) % 16))
        begin errors++; $display("FAIL rand_comb[%0d]: sel=%b s_sel=%b plus1=%0d s_plus1=%0d required %b/%b/%0d/%0d", n, m_sel, s_sel, m_plus1, s_plus1, model_sel(), model_sel(), (m_pc + 1) % 1024, (s_pc + 1) % 16); end
      tick();
      checks++;
      if (m_pc_o !== 10'(m_pc) || s_pc_o !== 4'(s_pc) || m_cnt_o !== 16'(m_cnt) || s_cnt_o !== 3'(s_cnt))
        begin errors++; $display("FAIL rand_regs[%0d]: pc=%0d s_pc=%0d cnt=%0d s_cnt=%0d required %0d/%0d/%0d/%0d", n, m_pc_o, s_pc_o, m_cnt_o, s_cnt_o, m_pc, s_pc, m_cnt, s_cnt); end
      checks++;
      if (m_busy !== m_run || m_fv !== m_run || m_done !== m_fin || s_busy !== m_run || s_fv !== m_run || s_done !== m_fin)
        begin errors++; $display("FAIL rand_flags[%0d]: busy=%b fv=%b done=%b s=%b%b%b required busy=%b done=%b", n, m_busy, m_fv, m_done, s_busy, s_fv, s_done, m_run, m_fin); end
    end
    clear_ctrl();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_wrap_saturate();
    test_start_in_run_and_done();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
